// File: rtl/demux_stripe_param.sv
// 1-to-LANES round-robin unstriping demultiplexer on clk_2f.
// Stream mode pulses one lane per word; gather mode presents a full group at once.
module demux_stripe_param #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  localparam int PTR_W = $clog2(LANES)
) (
  input  logic                    clk_2f,
  input  logic                    reset,
  input  logic                    mode,
  input  logic                    sync_in,
  input  logic                    valid_in,
  input  logic [DATA_W-1:0]       data_in,
  output logic [LANES-1:0]        valid_out,
  output logic [LANES*DATA_W-1:0] data_out,
  output logic [PTR_W-1:0]        lane_ptr,
  output logic                    group_done
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(LANES - 1);

  logic [PTR_W-1:0]                 ptr_q, ptr_d;
  logic                             mode_q, mode_d;
  logic [LANES-2:0][DATA_W-1:0]     buf_q, buf_d;
  logic [LANES-1:0][DATA_W-1:0]     data_q, data_d;
  logic [LANES-1:0]                 valid_q, valid_d;
  logic                             done_q, done_d;
  logic [PTR_W-1:0]                 eff_ptr;

  // A sync realigns the incoming word (if any) to lane 0.
  assign eff_ptr = sync_in ? '0 : ptr_q;

  always_comb begin
    ptr_d   = ptr_q;
    mode_d  = mode_q;
    buf_d   = buf_q;
    data_d  = data_q;
    valid_d = '0;
    done_d  = 1'b0;

    if (sync_in) begin
      ptr_d  = '0;
      mode_d = mode;
      buf_d  = '0;
    end

    if (valid_in) begin
      if (eff_ptr == '0) begin
        mode_d = mode;
      end
      ptr_d  = eff_ptr + PTR_W'(1);
      done_d = (eff_ptr == LAST);

      if (!mode_d) begin
        for (int k = 0; k < LANES; k++) begin
          if (eff_ptr == PTR_W'(k)) begin
            data_d[k]  = data_in;
            valid_d[k] = 1'b1;
          end
        end
      end else if (eff_ptr == LAST) begin
        for (int k = 0; k < LANES - 1; k++) begin
          data_d[k] = buf_q[k];
        end
        data_d[LANES-1] = data_in;
        valid_d         = '1;
      end else begin
        for (int k = 0; k < LANES - 1; k++) begin
          if (eff_ptr == PTR_W'(k)) begin
            buf_d[k] = data_in;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      ptr_q   <= '0;
      mode_q  <= 1'b0;
      buf_q   <= '0;
      data_q  <= '0;
      valid_q <= '0;
      done_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      mode_q  <= mode_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign valid_out  = valid_q;
  assign data_out   = data_q;
  assign lane_ptr   = ptr_q;
  assign group_done = done_q;

endmodule

// File: tb/tb_demux_stripe_param.sv
// Bench for demux_stripe_param: directed vector table, async reset sequence,
// randomized run against a queue-based model, and a LANES=2/8 sweep.
module tb_demux_stripe_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-lane, 8-bit instance
  logic        mode, sync_in, valid_in;
  logic [7:0]  data_in;
  logic [3:0]  valid_out;
  logic [31:0] data_out;
  logic [1:0]  lane_ptr;
  logic        group_done;

  // sweep instances share stimulus
  logic        sw_mode, sw_sync, sw_valid;
  logic [15:0] sw_data;
  logic [1:0]  v2;
  logic [31:0] d2;
  logic [0:0]  p2;
  logic        g2;
  logic [7:0]  v8;
  logic [127:0] d8;
  logic [2:0]  p8;
  logic        g8;

  demux_stripe_param #(.DATA_W(8), .LANES(4)) u_dut (
    .clk_2f(clk), .reset(rst), .mode(mode), .sync_in(sync_in), .valid_in(valid_in),
    .data_in(data_in), .valid_out(valid_out), .data_out(data_out),
    .lane_ptr(lane_ptr), .group_done(group_done));

  demux_stripe_param #(.DATA_W(16), .LANES(2)) u_dut2 (
    .clk_2f(clk), .reset(rst), .mode(sw_mode), .sync_in(sw_sync), .valid_in(sw_valid),
    .data_in(sw_data), .valid_out(v2), .data_out(d2), .lane_ptr(p2), .group_done(g2));

  demux_stripe_param #(.DATA_W(16), .LANES(8)) u_dut8 (
    .clk_2f(clk), .reset(rst), .mode(sw_mode), .sync_in(sw_sync), .valid_in(sw_valid),
    .data_in(sw_data), .valid_out(v8), .data_out(d8), .lane_ptr(p8), .group_done(g8));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mode = 0; sync_in = 0; valid_in = 0; data_in = '0;
    sw_mode = 0; sw_sync = 0; sw_valid = 0; sw_data = '0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // ---------------- behavioural reference model (4 lanes) ----------------
  int         m_ptr;
  bit         m_mode;
  logic [7:0] grp_q[$];
  logic [7:0] m_data[4];
  logic [3:0] m_valid;
  bit         m_done;

  task automatic model_reset();
    m_ptr = 0; m_mode = 0; grp_q.delete(); m_valid = '0; m_done = 0;
    for (int k = 0; k < 4; k++) m_data[k] = '0;
  endtask

  task automatic model_step(input bit md, input bit s, input bit v, input logic [7:0] d);
    int lane;
    m_valid = '0;
    m_done  = 0;
    if (s) begin
      grp_q.delete();
      m_ptr  = 0;
      m_mode = md;
    end
    if (v) begin
      if (m_ptr == 0) m_mode = md;
      lane = m_ptr;
      if (!m_mode) begin
        m_data[lane] = d;
        m_valid[lane] = 1'b1;
      end else begin
        grp_q.push_back(d);
        if (grp_q.size() == 4) begin
          for (int k = 0; k < 4; k++) m_data[k] = grp_q[k];
          m_valid = 4'hF;
          grp_q.delete();
        end
      end
      m_done = (lane == 3);
      m_ptr  = (m_ptr + 1) % 4;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          m;
    bit          s;
    bit          v;
    logic [7:0]  d;
    logic [3:0]  ev;
    logic [31:0] ed;
    logic [1:0]  ep;
    bit          eg;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit m, bit s, bit v, logic [7:0] d, logic [3:0] ev,
                              logic [31:0] ed, logic [1:0] ep, bit eg);
    vec_t r;
    r.m = m; r.s = s; r.v = v; r.d = d; r.ev = ev; r.ed = ed; r.ep = ep; r.eg = eg;
    return r;
  endfunction

  initial begin
    // stream basic
    tbl.push_back(mk(0,0,1,8'hA0,4'h1,32'h000000A0,2'd1,0));
    tbl.push_back(mk(0,0,1,8'hA1,4'h2,32'h0000A1A0,2'd2,0));
    tbl.push_back(mk(0,0,1,8'hA2,4'h4,32'h00A2A1A0,2'd3,0));
    tbl.push_back(mk(0,0,1,8'hA3,4'h8,32'hA3A2A1A0,2'd0,1));
    tbl.push_back(mk(0,0,0,8'h00,4'h0,32'hA3A2A1A0,2'd0,0));
    // gather with a 2-cycle gap
    tbl.push_back(mk(1,0,1,8'h10,4'h0,32'hA3A2A1A0,2'd1,0));
    tbl.push_back(mk(1,0,1,8'h11,4'h0,32'hA3A2A1A0,2'd2,0));
    tbl.push_back(mk(1,0,0,8'h00,4'h0,32'hA3A2A1A0,2'd2,0));
    tbl.push_back(mk(1,0,0,8'h00,4'h0,32'hA3A2A1A0,2'd2,0));
    tbl.push_back(mk(1,0,1,8'h12,4'h0,32'hA3A2A1A0,2'd3,0));
    tbl.push_back(mk(1,0,1,8'h13,4'hF,32'h13121110,2'd0,1));
    tbl.push_back(mk(1,0,0,8'h00,4'h0,32'h13121110,2'd0,0));
    // mode change mid-group
    tbl.push_back(mk(0,0,1,8'h40,4'h1,32'h13121140,2'd1,0));
    tbl.push_back(mk(0,0,1,8'h41,4'h2,32'h13124140,2'd2,0));
    tbl.push_back(mk(1,0,1,8'h42,4'h4,32'h13424140,2'd3,0));
    tbl.push_back(mk(1,0,1,8'h43,4'h8,32'h43424140,2'd0,1));
    tbl.push_back(mk(1,0,1,8'h50,4'h0,32'h43424140,2'd1,0));
    tbl.push_back(mk(1,0,1,8'h51,4'h0,32'h43424140,2'd2,0));
    tbl.push_back(mk(1,0,1,8'h52,4'h0,32'h43424140,2'd3,0));
    tbl.push_back(mk(1,0,1,8'h53,4'hF,32'h53525150,2'd0,1));
    // resync with valid
    tbl.push_back(mk(1,0,1,8'h20,4'h0,32'h53525150,2'd1,0));
    tbl.push_back(mk(1,0,1,8'h21,4'h0,32'h53525150,2'd2,0));
    tbl.push_back(mk(1,1,1,8'h30,4'h0,32'h53525150,2'd1,0));
    tbl.push_back(mk(1,0,1,8'h31,4'h0,32'h53525150,2'd2,0));
    tbl.push_back(mk(1,0,1,8'h32,4'h0,32'h53525150,2'd3,0));
    tbl.push_back(mk(1,0,1,8'h33,4'hF,32'h33323130,2'd0,1));
    // resync without valid discards the partial group
    tbl.push_back(mk(1,0,1,8'h60,4'h0,32'h33323130,2'd1,0));
    tbl.push_back(mk(1,1,0,8'h00,4'h0,32'h33323130,2'd0,0));
    tbl.push_back(mk(1,0,1,8'h61,4'h0,32'h33323130,2'd1,0));
    tbl.push_back(mk(1,0,1,8'h62,4'h0,32'h33323130,2'd2,0));
    tbl.push_back(mk(1,0,1,8'h63,4'h0,32'h33323130,2'd3,0));
    tbl.push_back(mk(1,0,1,8'h64,4'hF,32'h64636261,2'd0,1));
    // resync in stream mode lands on lane 0
    tbl.push_back(mk(0,0,1,8'h80,4'h1,32'h64636280,2'd1,0));
    tbl.push_back(mk(0,1,1,8'h81,4'h1,32'h64636281,2'd1,0));
    tbl.push_back(mk(0,0,1,8'h82,4'h2,32'h64638281,2'd2,0));

    do_reset();
    chk("rst_valid", 128'(valid_out), 128'(4'h0));
    chk("rst_data",  128'(data_out),  128'(32'h0));
    chk("rst_ptr",   128'(lane_ptr),  128'(2'd0));
    chk("rst_done",  128'(group_done), 128'(1'b0));

    for (int i = 0; i < tbl.size(); i++) begin
      mode = tbl[i].m; sync_in = tbl[i].s; valid_in = tbl[i].v; data_in = tbl[i].d;
      cyc();
      chk($sformatf("tbl%0d_valid", i), 128'(valid_out),  128'(tbl[i].ev));
      chk($sformatf("tbl%0d_data", i),  128'(data_out),   128'(tbl[i].ed));
      chk($sformatf("tbl%0d_ptr", i),   128'(lane_ptr),   128'(tbl[i].ep));
      chk($sformatf("tbl%0d_done", i),  128'(group_done), 128'(tbl[i].eg));
    end

    // async reset between edges after three gather words
    mode = 1; sync_in = 1; valid_in = 1; data_in = 8'h90;
    cyc();
    sync_in = 0; data_in = 8'h91;
    cyc();
    data_in = 8'h92;
    cyc();
    valid_in = 0;
    chk("pre_arst_ptr", 128'(lane_ptr), 128'(2'd3));
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", 128'(valid_out), 128'(4'h0));
    chk("arst_data",  128'(data_out),  128'(32'h0));
    chk("arst_ptr",   128'(lane_ptr),  128'(2'd0));
    chk("arst_done",  128'(group_done), 128'(1'b0));
    #2 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mode = 1; valid_in = 1; data_in = 8'h70 + 8'(k);
      cyc();
      chk($sformatf("post_arst%0d_valid", k), 128'(valid_out), 128'((k == 3) ? 4'hF : 4'h0));
      chk($sformatf("post_arst%0d_data", k), 128'(data_out),
          128'((k == 3) ? 32'h73727170 : 32'h0));
      chk($sformatf("post_arst%0d_done", k), 128'(group_done), 128'(k == 3));
    end
    valid_in = 0;

    // randomized run against the model
    do_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      mode     = ($urandom_range(0, 7) < 3);
      sync_in  = ($urandom_range(0, 11) == 0);
      valid_in = ($urandom_range(0, 3) != 0);
      data_in  = 8'($urandom);
      model_step(mode, sync_in, valid_in, data_in);
      cyc();
      chk($sformatf("rnd%0d_valid", i), 128'(valid_out), 128'(m_valid));
      chk($sformatf("rnd%0d_data", i), 128'(data_out),
          128'({m_data[3], m_data[2], m_data[1], m_data[0]}));
      chk($sformatf("rnd%0d_ptr", i), 128'(lane_ptr), 128'(m_ptr));
      chk($sformatf("rnd%0d_done", i), 128'(group_done), 128'(m_done));
    end

    // LANES=2 and LANES=8 sweep, stream then gather, continuous incrementing data
    for (int g = 0; g < 2; g++) begin
      do_reset();
      for (int n = 0; n < 32; n++) begin
        int l2, l8;
        sw_mode = g[0]; sw_valid = 1; sw_data = 16'(n);
        cyc();
        l2 = n % 2;
        l8 = n % 8;
        chk($sformatf("sw2_g%0d_n%0d_ptr", g, n), 128'(p2), 128'((n + 1) % 2));
        chk($sformatf("sw2_g%0d_n%0d_done", g, n), 128'(g2), 128'(l2 == 1));
        chk($sformatf("sw8_g%0d_n%0d_ptr", g, n), 128'(p8), 128'((n + 1) % 8));
        chk($sformatf("sw8_g%0d_n%0d_done", g, n), 128'(g8), 128'(l8 == 7));
        if (g == 0) begin
          chk($sformatf("sw2_n%0d_valid", n), 128'(v2), 128'(1 << l2));
          chk($sformatf("sw2_n%0d_data", n), 128'(d2[l2*16 +: 16]), 128'(n));
          chk($sformatf("sw8_n%0d_valid", n), 128'(v8), 128'(1 << l8));
          chk($sformatf("sw8_n%0d_data", n), 128'(d8[l8*16 +: 16]), 128'(n));
        end else begin
          chk($sformatf("gw2_n%0d_valid", n), 128'(v2), 128'((l2 == 1) ? 2'b11 : 2'b00));
          chk($sformatf("gw8_n%0d_valid", n), 128'(v8), 128'((l8 == 7) ? 8'hFF : 8'h00));
          if (l2 == 1) begin
            for (int k = 0; k < 2; k++)
              chk($sformatf("gw2_n%0d_l%0d", n, k), 128'(d2[k*16 +: 16]), 128'(n - 1 + k));
          end
          if (l8 == 7) begin
            for (int k = 0; k < 8; k++)
              chk($sformatf("gw8_n%0d_l%0d", n, k), 128'(d8[k*16 +: 16]), 128'(n - 7 + k));
          end
        end
      end
      sw_valid = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
